// File: rtl/pc_gen_pkg.sv
// Shared constants and enums for the next-PC generator.
package pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR_DEF = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IRQ_PEND = 2'd1,
    ST_IRQ_TAKE = 2'd2
  } irq_state_e;

  typedef enum logic [2:0] {
    CAUSE_SEQ    = 3'd0,
    CAUSE_EXC    = 3'd1,
    CAUSE_BRANCH = 3'd2,
    CAUSE_IRQ    = 3'd3,
    CAUSE_STALL  = 3'd4,
    CAUSE_JR     = 3'd5,
    CAUSE_JUMP   = 3'd6
  } redirect_e;

  // Upper half of the address map is kernel space; interrupts are masked there.
  function automatic logic is_kernel(input logic [31:0] pc);
    return pc[31];
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control-flow inputs from the pipeline and redirect/trap outputs of pc_gen.
interface pc_gen_if;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exc;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        irq;

  logic [31:0] pc_next;
  logic [31:0] pc_q;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] epc;
  logic        epc_we;
  logic        irq_ack;

  modport slave (
    input  stall, br_taken, br_target, jump, jump_target, jr, jr_target,
           exc, id_pc, id_valid, irq,
    output pc_next, pc_q, flush_if_id, flush_id_ex, epc, epc_we, irq_ack
  );

  modport master (
    output stall, br_taken, br_target, jump, jump_target, jr, jr_target,
           exc, id_pc, id_valid, irq,
    input  pc_next, pc_q, flush_if_id, flush_id_ex, epc, epc_we, irq_ack
  );
endinterface

// File: rtl/pc_redirect_mux.sv
// Priority selection of the next fetch address plus flush / EPC decode.
module pc_redirect_mux
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        i_irq_take,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic        i_jump,
  input  logic        i_jr,
  input  logic        i_exc,
  input  logic        i_id_valid,
  input  logic [31:0] i_pc_q,
  input  logic [31:0] i_br_target,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_jr_target,
  input  logic [31:0] i_id_pc,
  output logic [31:0] o_pc_next,
  output logic [31:0] o_epc_wdata,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_epc_we,
  output logic        o_irq_ack
);

  redirect_e w_cause;

  always_comb begin
    w_cause = CAUSE_SEQ;
    if (i_exc)           w_cause = CAUSE_EXC;
    else if (i_br_taken) w_cause = CAUSE_BRANCH;
    else if (i_irq_take) w_cause = CAUSE_IRQ;
    else if (i_stall)    w_cause = CAUSE_STALL;
    else if (i_jr)       w_cause = CAUSE_JR;
    else if (i_jump)     w_cause = CAUSE_JUMP;
  end

  always_comb begin
    o_pc_next     = i_pc_q + 32'd4;
    o_epc_wdata   = i_id_pc;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    o_epc_we      = 1'b0;
    o_irq_ack     = 1'b0;
    unique case (w_cause)
      CAUSE_EXC: begin
        o_pc_next     = EXC_VECTOR;
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
        o_epc_we      = 1'b1;
      end
      CAUSE_BRANCH: begin
        o_pc_next     = i_br_target;
        o_flush_if_id = 1'b1;
        o_flush_id_ex = 1'b1;
      end
      CAUSE_IRQ: begin
        // A bubble in ID has no PC of its own; resume at the instruction in fetch.
        o_pc_next     = IRQ_VECTOR;
        o_epc_wdata   = i_id_valid ? i_id_pc : i_pc_q;
        o_flush_if_id = 1'b1;
        o_epc_we      = 1'b1;
        o_irq_ack     = 1'b1;
      end
      CAUSE_STALL: o_pc_next = i_pc_q;
      CAUSE_JR: begin
        o_pc_next     = i_jr_target;
        o_flush_if_id = 1'b1;
      end
      CAUSE_JUMP: begin
        o_pc_next     = i_jump_target;
        o_flush_if_id = 1'b1;
      end
      default: o_pc_next = i_pc_q + 32'd4;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Next-PC generator: fetch PC register, EPC register and interrupt-entry FSM.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic   clk,
  input  logic   reset,
  pc_gen_if.slave bus
);

  irq_state_e  r_state;
  irq_state_e  w_state_next;
  logic [31:0] r_pc_q;
  logic [31:0] r_epc;
  logic [31:0] w_pc_next;
  logic [31:0] w_epc_wdata;
  logic        w_flush_if_id;
  logic        w_flush_id_ex;
  logic        w_epc_we;
  logic        w_irq_ack;
  logic        w_kernel;
  logic        w_busy;

  assign w_kernel = is_kernel(r_pc_q);
  assign w_busy   = bus.stall | bus.br_taken | bus.jump | bus.jr;

  pc_redirect_mux #(
    .IRQ_VECTOR (IRQ_VECTOR),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_mux (
    .i_irq_take    (r_state == ST_IRQ_TAKE),
    .i_stall       (bus.stall),
    .i_br_taken    (bus.br_taken),
    .i_jump        (bus.jump),
    .i_jr          (bus.jr),
    .i_exc         (bus.exc),
    .i_id_valid    (bus.id_valid),
    .i_pc_q        (r_pc_q),
    .i_br_target   (bus.br_target),
    .i_jump_target (bus.jump_target),
    .i_jr_target   (bus.jr_target),
    .i_id_pc       (bus.id_pc),
    .o_pc_next     (w_pc_next),
    .o_epc_wdata   (w_epc_wdata),
    .o_flush_if_id (w_flush_if_id),
    .o_flush_id_ex (w_flush_id_ex),
    .o_epc_we      (w_epc_we),
    .o_irq_ack     (w_irq_ack)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc_q  <= RESET_PC;
      r_epc   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc_q  <= w_pc_next;
      if (w_epc_we) r_epc <= w_epc_wdata;
    end
  end

  // Interrupt entry waits for a cycle with no redirect or stall in flight.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (bus.irq && !w_kernel && !bus.exc)
          w_state_next = w_busy ? ST_IRQ_PEND : ST_IRQ_TAKE;
      end
      ST_IRQ_PEND: begin
        if (!bus.irq || w_kernel || bus.exc) w_state_next = ST_RUN;
        else if (!w_busy)                    w_state_next = ST_IRQ_TAKE;
      end
      ST_IRQ_TAKE: begin
        w_state_next = (bus.exc || bus.br_taken) ? ST_IRQ_PEND : ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign bus.pc_next     = w_pc_next;
  assign bus.pc_q        = r_pc_q;
  assign bus.flush_if_id = w_flush_if_id;
  assign bus.flush_id_ex = w_flush_id_ex;
  assign bus.epc         = w_epc_we ? w_epc_wdata : r_epc;
  assign bus.epc_we      = w_epc_we;
  assign bus.irq_ack     = w_irq_ack;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: redirect priority, interrupt entry and EPC.
module tb_pc_gen;

  typedef struct {
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic        f1;
    logic        f2;
    logic [31:0] epc;
    logic        we;
    logic        ack;
  } exp_t;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_errors;
  exp_t sb[$];

  pc_gen_if bus ();

  pc_gen #(
    .RESET_PC   (32'h0000_0000),
    .IRQ_VECTOR (32'h8000_0004),
    .EXC_VECTOR (32'h8000_0008)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pcq, input logic [31:0] pcn,
                              input logic f1, input logic f2, input logic [31:0] epc,
                              input logic we, input logic ack);
    exp_t e;
    e.pc_q = pcq; e.pc_next = pcn; e.f1 = f1; e.f2 = f2;
    e.epc = epc; e.we = we; e.ack = ack;
    return e;
  endfunction

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("pc_q",        bus.pc_q,               e.pc_q);
    check("pc_next",     bus.pc_next,            e.pc_next);
    check("flush_if_id", 32'(bus.flush_if_id),   32'(e.f1));
    check("flush_id_ex", 32'(bus.flush_id_ex),   32'(e.f2));
    check("epc",         bus.epc,                e.epc);
    check("epc_we",      32'(bus.epc_we),        32'(e.we));
    check("irq_ack",     32'(bus.irq_ack),       32'(e.ack));
  endtask

  task automatic drive(input logic st, input logic br, input logic jmp, input logic jrr,
                       input logic ex, input logic irqv, input logic [31:0] tgt,
                       input logic [31:0] idpc, input logic idv);
    bus.stall       = st;
    bus.br_taken    = br;
    bus.jump        = jmp;
    bus.jr          = jrr;
    bus.exc         = ex;
    bus.irq         = irqv;
    bus.br_target   = tgt;
    bus.jump_target = tgt;
    bus.jr_target   = tgt;
    bus.id_pc       = idpc;
    bus.id_valid    = idv;
  endtask

  task automatic quiet();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  // Inputs already driven; expectation queued, checked mid-cycle, then one edge.
  task automatic go(input logic [31:0] pcq, input logic [31:0] pcn, input logic f1,
                    input logic f2, input logic [31:0] epc, input logic we, input logic ack);
    sb.push_back(mk(pcq, pcn, f1, f2, epc, we, ack));
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    quiet();
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk(32'h0, 32'h4, 0, 0, 32'h0, 0, 0));
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
    reset = 1'b0;

    go(32'h0,  32'h4,  0, 0, 32'h0, 0, 0);
    go(32'h4,  32'h8,  0, 0, 32'h0, 0, 0);
    go(32'h8,  32'hC,  0, 0, 32'h0, 0, 0);
    go(32'hC,  32'h10, 0, 0, 32'h0, 0, 0);

    drive(0, 0, 1, 0, 0, 0, 32'h20, 32'h0, 1);
    go(32'h10, 32'h20, 1, 0, 32'h0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    go(32'h20, 32'h20, 0, 0, 32'h0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 32'h300, 32'h0, 1);
    go(32'h20, 32'h20, 0, 0, 32'h0, 0, 0);
    quiet();
    go(32'h20, 32'h24, 0, 0, 32'h0, 0, 0);

    drive(1, 1, 1, 0, 0, 0, 32'h100, 32'h0, 1);
    bus.jump_target = 32'h700;
    go(32'h24, 32'h100, 1, 1, 32'h0, 0, 0);
    drive(0, 0, 1, 1, 0, 0, 32'h38, 32'h0, 1);
    bus.jump_target = 32'h500;
    go(32'h100, 32'h38, 1, 0, 32'h0, 0, 0);
    quiet();
    go(32'h38, 32'h3C, 0, 0, 32'h0, 0, 0);
    go(32'h3C, 32'h40, 0, 0, 32'h0, 0, 0);

    // quiet interrupt entry
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h3C, 1);
    go(32'h40, 32'h44, 0, 0, 32'h0, 0, 0);
    go(32'h44, 32'h8000_0004, 1, 0, 32'h3C, 1, 1);
    go(32'h8000_0004, 32'h8000_0008, 0, 0, 32'h3C, 0, 0);

    // irq coincident with jump
    drive(0, 0, 1, 0, 0, 0, 32'h1F0, 32'h0, 1);
    go(32'h8000_0008, 32'h1F0, 1, 0, 32'h3C, 0, 0);
    drive(0, 0, 1, 0, 0, 1, 32'h200, 32'h1EC, 1);
    go(32'h1F0, 32'h200, 1, 0, 32'h3C, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h1F0, 1);
    go(32'h200, 32'h204, 0, 0, 32'h3C, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h200, 1);
    go(32'h204, 32'h8000_0004, 1, 0, 32'h200, 1, 1);

    // exception during IRQ_TAKE, then masked in kernel
    drive(0, 0, 1, 0, 0, 0, 32'h4C, 32'h0, 1);
    go(32'h8000_0004, 32'h4C, 1, 0, 32'h200, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h48, 1);
    go(32'h4C, 32'h50, 0, 0, 32'h200, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 32'h0, 32'h50, 1);
    go(32'h50, 32'h8000_0008, 1, 1, 32'h50, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1);
    go(32'h8000_0008, 32'h8000_000C, 0, 0, 32'h50, 0, 0);
    go(32'h8000_000C, 32'h8000_0010, 0, 0, 32'h50, 0, 0);

    // entry with a bubble in ID: epc falls back to pc_q
    drive(0, 0, 1, 0, 0, 0, 32'h60, 32'h0, 1);
    go(32'h8000_0010, 32'h60, 1, 0, 32'h50, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h5C, 1);
    go(32'h60, 32'h64, 0, 0, 32'h50, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h5C, 0);
    go(32'h64, 32'h8000_0004, 1, 0, 32'h64, 1, 1);

    // +4 wraps at the top of the address space
    drive(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 1);
    go(32'h8000_0004, 32'hFFFF_FFFC, 1, 0, 32'h64, 0, 0);
    quiet();
    go(32'hFFFF_FFFC, 32'h0, 0, 0, 32'h64, 0, 0);

    // asynchronous reset while in IRQ_TAKE discards the pending entry
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1);
    go(32'h0, 32'h4, 0, 0, 32'h64, 0, 0);
    reset = 1'b1;
    quiet();
    sb.push_back(mk(32'h0, 32'h4, 0, 0, 32'h0, 0, 0));
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
    reset = 1'b0;
    go(32'h0, 32'h4, 0, 0, 32'h0, 0, 0);

    // branch during IRQ_TAKE retries entry
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 1);
    go(32'h4, 32'h8, 0, 0, 32'h0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 32'h80, 32'h0, 1);
    go(32'h8, 32'h80, 1, 1, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h7C, 1);
    go(32'h80, 32'h84, 0, 0, 32'h0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h80, 1);
    go(32'h84, 32'h8000_0004, 1, 0, 32'h80, 1, 1);

    if (sb.size() != 0) check("scoreboard_left", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
